shared_bus_ctrl: RTL



---
 rtl/shared_bus_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shared_bus_ctrl.sv
// Shared bus controller: moves beats from the arbiter-granted source into a
// one-entry registered output stage, with per-source beat stats and error flags.
module shared_bus_ctrl #(
    parameter int DW      = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         granted_req,
    input  logic [2:0]         src_valid,
    input  logic [3*DW-1:0]    src_data,
    output logic [2:0]         src_ready,
    output logic               bus_valid,
    output logic [DW-1:0]      bus_data,
    output logic [1:0]         bus_id,
    input  logic               bus_ready,
    input  logic               stats_clr,
    output logic [3*CNT_W-1:0] xfer_cnt,
    output logic               grant_err,
    output logic               stall_err
);

    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0]    STALL_MAX = SW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, stateNext;
    logic              grantOk, space, accept, stalled;
    logic [1:0]        acceptId;
    logic [DW-1:0]     acceptData;
    logic [CNT_W-1:0]  cnt [3];
    logic [SW-1:0]     stallCnt, stallNext;

    // Readiness depends only on grant, output occupancy and reset, never on src_valid.
    always_comb begin
        grantOk   = (granted_req == 3'b001) || (granted_req == 3'b010) || (granted_req == 3'b100);
        space     = (state == EMPTY) || bus_ready;
        src_ready = (reset && grantOk && space) ? granted_req : 3'b000;
        accept    = |(src_valid & src_ready);
    end

    always_comb begin
        acceptId   = 2'd0;
        acceptData = src_data[0 +: DW];
        case (granted_req)
            3'b010: begin
                acceptId   = 2'd1;
                acceptData = src_data[DW +: DW];
            end
            3'b100: begin
                acceptId   = 2'd2;
                acceptData = src_data[2*DW +: DW];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            EMPTY:   if (accept) stateNext = FULL;
            FULL:    if (bus_ready && !accept) stateNext = EMPTY;
            default: stateNext = EMPTY;
        endcase
    end

    always_comb begin
        bus_valid = (state == FULL);
        stalled   = bus_valid && !bus_ready;
    end

    // Loading only on accept keeps data and id frozen while the downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_data <= '0;
            bus_id   <= 2'd0;
        end else if (accept) begin
            bus_data <= acceptData;
            bus_id   <= acceptId;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (stats_clr)
                    cnt[i] <= '0;
                else if (accept && acceptId == 2'(i) && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        xfer_cnt = '0;
        for (int i = 0; i < 3; i++) xfer_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_comb begin
        if (!stalled)                   stallNext = '0;
        else if (stallCnt == STALL_MAX) stallNext = STALL_MAX;
        else                            stallNext = stallCnt + 1'b1;
    end

    // Error flags are sticky until reset; stall_err rises on the edge the count hits TIMEOUT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt  <= '0;
            stall_err <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            stallCnt <= stallNext;
            if (stallNext == STALL_MAX)              stall_err <= 1'b1;
            if (!grantOk && granted_req != 3'b000)   grant_err <= 1'b1;
        end
    end

endmodule
